// File: rtl/obi_axil_pkg.sv
// Shared types and constants for the OBI to AXI4-Lite bridge.
// txn_type_e tags each granted transaction so responses can be steered back in grant order.
// The AXI response encodings are collected here for both RTL and bench.
package obi_axil_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } txn_type_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/obi_axil_order_fifo.sv
// Order FIFO: records the type (READ/WRITE) of every granted transaction so the bridge can
// accept R and B beats strictly in grant order.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          enqueue push_type_i (one per OBI grant)
//   push_type_i     type of the granted transaction
//   pop_i           dequeue head (one per accepted R or B beat)
//   full_o, empty_o occupancy flags (registered count)
//   head_o          type of the oldest outstanding transaction
module obi_axil_order_fifo
   import obi_axil_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  txn_type_e push_type_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output txn_type_e head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   txn_type_e        mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   // Pointers wrap modulo Depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (pop_i)  rptr_d = ptr_inc(rptr_q);
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= READ;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (push_i) mem_q[wptr_q] <= push_type_i;
      end
   end

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];

`ifndef SYNTHESIS
   // The bridge never raises a request while full and never accepts a beat while empty.
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));
`endif

endmodule

// File: rtl/obi_axil_bridge.sv
// OBI (core side) to AXI4-Lite (manager side) bridge.
// Reads map to AR/R, writes to AW+W/B. The OBI grant is given when the address phase has fully
// completed on AXI; up to MAX_OUTST granted transactions may await their response, which are
// returned to OBI in grant order with no added latency.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   obi_req_i/gnt_o/we_i/be_i/addr_i/wdata_i  OBI request channel
//   obi_rvalid_o/rdata_o/err_o             OBI response channel
//   m_axi_ar*, m_axi_r*                    AXI-lite read address / data channels
//   m_axi_aw*, m_axi_w*, m_axi_b*          AXI-lite write address / data / response channels
//   busy_o                                 any transaction outstanding or partially issued
module obi_axil_bridge
   import obi_axil_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   // OBI
   input  logic                obi_req_i,
   output logic                obi_gnt_o,
   input  logic                obi_we_i,
   input  logic [DATA_W/8-1:0] obi_be_i,
   input  logic [ADDR_W-1:0]   obi_addr_i,
   input  logic [DATA_W-1:0]   obi_wdata_i,
   output logic                obi_rvalid_o,
   output logic [DATA_W-1:0]   obi_rdata_o,
   output logic                obi_err_o,
   // AXI-lite read
   output logic                m_axi_arvalid_o,
   input  logic                m_axi_arready_i,
   output logic [ADDR_W-1:0]   m_axi_araddr_o,
   input  logic                m_axi_rvalid_i,
   output logic                m_axi_rready_o,
   input  logic [DATA_W-1:0]   m_axi_rdata_i,
   input  logic [1:0]          m_axi_rresp_i,
   // AXI-lite write
   output logic                m_axi_awvalid_o,
   input  logic                m_axi_awready_i,
   output logic [ADDR_W-1:0]   m_axi_awaddr_o,
   output logic                m_axi_wvalid_o,
   input  logic                m_axi_wready_i,
   output logic [DATA_W-1:0]   m_axi_wdata_o,
   output logic [DATA_W/8-1:0] m_axi_wstrb_o,
   input  logic                m_axi_bvalid_i,
   output logic                m_axi_bready_o,
   input  logic [1:0]          m_axi_bresp_i,
   // Status
   output logic                busy_o
);

   logic      aw_done_q, aw_done_d;
   logic      w_done_q, w_done_d;
   logic      full, empty;
   txn_type_e head;
   logic      rd_req, wr_req;
   logic      aw_hs, w_hs;
   logic      rd_gnt, wr_gnt;
   logic      r_acc, b_acc;
   logic      push, pop;
   txn_type_e push_type;

   // Combinational outputs are additionally qualified by rst_ni so they drop the moment reset
   // asserts, even while the OBI request is still held.
   assign rd_req = rst_ni & obi_req_i & ~obi_we_i & ~full;
   assign wr_req = rst_ni & obi_req_i & obi_we_i & ~full;

   assign m_axi_arvalid_o = rd_req;
   assign m_axi_araddr_o  = obi_addr_i;
   assign m_axi_awvalid_o = wr_req & ~aw_done_q;
   assign m_axi_awaddr_o  = obi_addr_i;
   assign m_axi_wvalid_o  = wr_req & ~w_done_q;
   assign m_axi_wdata_o   = obi_wdata_i;
   assign m_axi_wstrb_o   = obi_be_i;

   assign aw_hs = m_axi_awvalid_o & m_axi_awready_i;
   assign w_hs  = m_axi_wvalid_o & m_axi_wready_i;

   assign rd_gnt = rd_req & m_axi_arready_i;
   // Write grant only once both AW and W have handshaken, now or earlier.
   assign wr_gnt = wr_req & (aw_done_q | aw_hs) & (w_done_q | w_hs);

   assign obi_gnt_o = rd_gnt | wr_gnt;
   assign push      = obi_gnt_o;
   assign push_type = wr_gnt ? WRITE : READ;

   always_comb begin
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      if (wr_gnt) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end else begin
         if (aw_hs) aw_done_d = 1'b1;
         if (w_hs)  w_done_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Only the channel matching the oldest outstanding transaction is ready.
   assign m_axi_rready_o = rst_ni & ~empty & (head == READ);
   assign m_axi_bready_o = rst_ni & ~empty & (head == WRITE);

   assign r_acc = m_axi_rvalid_i & m_axi_rready_o;
   assign b_acc = m_axi_bvalid_i & m_axi_bready_o;
   assign pop   = r_acc | b_acc;

   assign obi_rvalid_o = pop;
   assign obi_rdata_o  = r_acc ? m_axi_rdata_i : '0;
   assign obi_err_o    = (r_acc & m_axi_rresp_i[1]) | (b_acc & m_axi_bresp_i[1]);

   assign busy_o = rst_ni & (~empty | aw_done_q | w_done_q);

   // EXOKAY vs OKAY and SLVERR vs DECERR are not distinguished on OBI.
   logic unused_resp_lsb;
   assign unused_resp_lsb = m_axi_rresp_i[0] ^ m_axi_bresp_i[0];

   obi_axil_order_fifo #(
      .Depth (MAX_OUTST)
   ) u_order_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push),
      .push_type_i (push_type),
      .pop_i       (pop),
      .full_o      (full),
      .empty_o     (empty),
      .head_o      (head)
   );

endmodule

// File: doc/obi_axil_bridge.md
OBI_AXIL_BRIDGE -- requirements
Module: obi_axil_bridge

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, address width of OBI and AXI channels.
REQ-002 SHALL provide parameter DATA_W, default 32, data width; strobe width DATA_W/8.
REQ-003 SHALL provide parameter MAX_OUTST, default 2, max accepted-but-unanswered transactions (>=1).
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 obi_req_i / obi_gnt_o  in/out  1/1  OBI request and grant.
REQ-007 obi_we_i / obi_be_i  in  1/DATA_W/8  write enable, byte enables.
REQ-008 obi_addr_i / obi_wdata_i  in  ADDR_W/DATA_W  request address, write data.
REQ-009 obi_rvalid_o / obi_rdata_o / obi_err_o  out  1/DATA_W/1  response valid, read data, error.
REQ-010 m_axi_ar{valid,ready,addr}, m_axi_r{valid,ready,data,resp}  AXI-lite read channels; resp 2 bits.
REQ-011 m_axi_aw{valid,ready,addr}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}  AXI-lite write channels.
REQ-012 busy_o  out  1  high while any transaction outstanding or partially issued.

Function
REQ-013 Read (req & !we): arvalid = req & !we & !full; araddr = obi_addr_i; obi_gnt_o in the cycle arvalid & arready.
REQ-014 Write (req & we): awvalid = req & we & !full & !aw_done; wvalid = req & we & !full & !w_done; AW and W handshake independently, in either order or same cycle.
REQ-015 aw_done/w_done registers set on their own handshake if grant not issued that cycle; both cleared on write grant.
REQ-016 Write obi_gnt_o in the cycle the second of AW/W handshakes completes (or both together); never earlier.
REQ-017 OBI rule: core holds req/addr/we/be/wdata stable until gnt; bridge relies on it.
REQ-018 Order FIFO, depth MAX_OUTST, 1-bit entries (READ/WRITE), push on every grant, pop on every response.
REQ-019 full = count == MAX_OUTST; no AR/AW/W valid raised while full; pop while full frees slot next cycle only.
REQ-020 rready = !empty & head==READ; bready = !empty & head==WRITE; responses returned strictly in grant order.
REQ-021 obi_rvalid_o = (rvalid & rready) | (bvalid & bready), combinational, zero added latency.
REQ-022 obi_rdata_o = rdata on read response, 0 otherwise; obi_err_o = resp[1] of the accepted R or B beat.
REQ-023 Simultaneous push and pop: count unchanged; head/tail pointers wrap modulo MAX_OUTST.
REQ-024 busy_o = !empty | aw_done | w_done.
REQ-025 Count width $clog2(MAX_OUTST+1); overflow/underflow impossible by construction, asserted in simulation.

Reset
REQ-026 On rst_ni low: FIFO empty, pointers/count 0, aw_done=w_done=0; all valid/ready and obi outputs 0 asynchronously.
REQ-027 Reset mid-operation discards partial writes and pending responses; AXI responses arriving after reset are not accepted (ready low while empty).

Structure
REQ-028 Package obi_axil_pkg SHALL hold txn_type_e (READ=0, WRITE=1) and AXI resp constants OKAY, EXOKAY, SLVERR, DECERR.
REQ-029 One sub-module obi_axil_order_fifo (parametrised depth, push/pop/full/empty/head) SHALL implement REQ-018/023.

Verification
REQ-030 Read at 0x100, arready=1, rvalid next cycle with rdata 0xDEADBEEF resp OKAY -> gnt same cycle as AR, obi_rvalid one cycle later, rdata 0xDEADBEEF, err 0.
REQ-031 Write 0x200 data 0x12345678 be 0xF, awready=1 cycle 0, wready=1 cycle 3 -> awvalid drops after cycle 0, gnt only in cycle 3, one B -> one obi_rvalid.
REQ-032 MAX_OUTST=2, three back-to-back reads, R withheld -> third arvalid stays low until first R beat accepted; data returned in order.
REQ-033 Read then write outstanding, bvalid raised before rvalid -> bready low until R accepted; responses delivered read then write.
REQ-034 Read returning resp SLVERR (2'b10) -> obi_err_o=1 with obi_rvalid_o.
REQ-035 Reset asserted after AW done, W pending -> all outputs 0 immediately, busy_o=0; post-reset write reissues AW and W.
